// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier.
// Each RUN cycle retires one Booth digit into a registered accumulator. An
// operation takes NBITS/2+1 cycles from the accepting edge to the done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted only in IDLE (level-sampled, no edge detection)
//   tc     1 = two's-complement operands, 0 = unsigned; sampled with start
//   mpd    multiplicand (MBITS); sampled with start
//   mpr    multiplier (NBITS); sampled with start
//   busy   high while an operation is in progress
//   done   one-cycle pulse when prod is updated
//   prod   product register (MBITS+NBITS); holds until the next done
//
// NBITS must be even and no greater than MBITS.
// COUNTBITS must satisfy 2**COUNTBITS > NBITS/2+1.
module booth_r4_seq_mult #(
  parameter int unsigned MBITS     = 12,
  parameter int unsigned NBITS     = 8,
  parameter int unsigned COUNTBITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   tc,
  input  logic [MBITS-1:0]       mpd,
  input  logic [NBITS-1:0]       mpr,
  output logic                   busy,
  output logic                   done,
  output logic [MBITS+NBITS-1:0] prod
);

  // Two guard bits keep the full-width accumulation exact in both modes.
  localparam int unsigned AW   = MBITS + NBITS + 2;
  localparam int unsigned ITER = NBITS / 2 + 1;
  localparam logic [COUNTBITS-1:0] LastCnt = COUNTBITS'(ITER - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 state_q;
  logic [AW-1:0]          acc_q;
  logic [AW-1:0]          mult_q;   // multiplicand, pre-shifted by 2i for the current digit
  logic [NBITS+2:0]       mpr_q;    // extended multiplier with implicit 0; window is [2:0]
  logic [COUNTBITS-1:0]   cnt_q;

  logic                   mpd_msb;
  logic                   mpr_msb;
  logic [AW-1:0]          mpd_ext;
  logic [NBITS+2:0]       mpr_ext;
  logic [AW-1:0]          mult2;
  logic [AW-1:0]          addend;
  logic [AW-1:0]          acc_next;

  // Operand extension: sign bit only counts in two's-complement mode.
  always_comb begin
    mpd_msb = tc & mpd[MBITS-1];
    mpr_msb = tc & mpr[NBITS-1];
    mpd_ext = {{(AW - MBITS){mpd_msb}}, mpd};
    mpr_ext = {{2{mpr_msb}}, mpr, 1'b0};
  end

  // Booth digit decode on the current window.
  always_comb begin
    addend = '0;
    mult2  = mult_q << 1;
    unique case (mpr_q[2:0])
      3'b001, 3'b010: addend = mult_q;
      3'b011:         addend = mult2;
      3'b100:         addend = ~mult2 + AW'(1);
      3'b101, 3'b110: addend = ~mult_q + AW'(1);
      default:        addend = '0;
    endcase
    acc_next = acc_q + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mult_q  <= '0;
      mpr_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mult_q  <= mpd_ext;
            mpr_q   <= mpr_ext;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q  <= acc_next;
          mult_q <= mult_q << 2;
          mpr_q  <= mpr_q >> 2;
          cnt_q  <= cnt_q + COUNTBITS'(1);
          if (cnt_q == LastCnt) begin
            prod    <= acc_next[MBITS+NBITS-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench for booth_r4_seq_mult: one instance at default widths and
// one at 16x16. Drivers push expected product and due cycle; monitors pop on done.
module tb_booth_r4_seq_mult;

  localparam int unsigned ITER   = 5;
  localparam int unsigned ITER16 = 9;

  typedef struct {
    logic [31:0] p;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start, tc;
  logic [11:0] mpd;
  logic [7:0]  mpr;
  logic        busy, done;
  logic [19:0] prod;

  logic        start16, tc16;
  logic [15:0] mpd16, mpr16;
  logic        busy16, done16;
  logic [31:0] prod16;

  exp_t        sb[$];
  exp_t        sb16[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [19:0] last_prod;
  logic [31:0] last_prod16;

  booth_r4_seq_mult #(.MBITS(12), .NBITS(8), .COUNTBITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .tc    (tc),
    .mpd   (mpd),
    .mpr   (mpr),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  booth_r4_seq_mult #(.MBITS(16), .NBITS(16), .COUNTBITS(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .tc    (tc16),
    .mpd   (mpd16),
    .mpr   (mpr16),
    .busy  (busy16),
    .done  (done16),
    .prod  (prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor, default-width instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_prod = '0;
    end else begin
      check("busy", 32'(busy), 32'((sb.size() != 0) && !done));
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)",
                   cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("prod", 32'(prod), 32'(e.p[19:0]));
          check("latency", cyc, e.due);
        end
        last_prod = prod;
      end else begin
        check("prod_hold", 32'(prod), 32'(last_prod));
      end
    end
  end

  // Monitor, 16x16 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_prod16 = '0;
    end else begin
      check("busy16", 32'(busy16), 32'((sb16.size() != 0) && !done16));
      if (done16) begin
        if (sb16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done16: got done=1, expected no pending result (cycle %0d)",
                   cyc);
        end else begin
          exp_t e;
          e = sb16.pop_front();
          check("prod16", prod16, e.p);
          check("latency16", cyc, e.due);
        end
        last_prod16 = prod16;
      end else begin
        check("prod_hold16", prod16, last_prod16);
      end
    end
  end

  // Issue one op to the idle default instance; operands are scrambled after E0.
  task automatic issue(input logic [11:0] a, input logic [7:0] b, input logic t,
                       input logic [19:0] exp);
    exp_t e;
    @(negedge clk);
    mpd = a; mpr = b; tc = t; start = 1'b1;
    @(posedge clk);
    #1;
    e.p = 32'(exp);
    e.due = cyc + ITER;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mpd = 12'($urandom);
    mpr = 8'($urandom);
    tc  = ~t;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic t,
                         input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    mpd16 = a; mpr16 = b; tc16 = t; start16 = 1'b1;
    @(posedge clk);
    #1;
    e.p = exp;
    e.due = cyc + ITER16;
    sb16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
    mpd16 = 16'($urandom);
    mpr16 = 16'($urandom);
    tc16  = ~t;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (sb.size() != 0 || sb16.size() != 0); i++) @(negedge clk);
    checks++;
    if (sb.size() != 0 || sb16.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending results, expected 0/0",
               sb.size(), sb16.size());
      sb.delete();
      sb16.delete();
    end
  endtask

  // Directed vectors for the default instance: {mpd, mpr, tc, expected prod}.
  typedef struct {
    logic [11:0] a;
    logic [7:0]  b;
    logic        t;
    logic [19:0] p;
  } vec_t;

  vec_t vecs[] = '{
    '{12'h003, 8'h05, 1'b0, 20'h0000F},
    '{12'hFFF, 8'hFF, 1'b0, 20'hFEF01},
    '{12'h800, 8'h80, 1'b1, 20'h40000},
    '{12'hFFF, 8'h01, 1'b1, 20'hFFFFF},
    '{12'hFFF, 8'h01, 1'b0, 20'h00FFF},
    '{12'h7FF, 8'h7F, 1'b1, 20'h3F781},
    '{12'h800, 8'h7F, 1'b1, 20'hC0800},
    '{12'hABC, 8'h5A, 1'b0, 20'h3C618},
    '{12'hABC, 8'hA5, 1'b1, 20'h1DF2C},
    '{12'h000, 8'hA5, 1'b1, 20'h00000},
    '{12'h800, 8'h80, 1'b0, 20'h40000}
  };

  initial begin
    rst_n = 1'b0;
    start = 1'b0; tc = 1'b0; mpd = '0; mpr = '0;
    start16 = 1'b0; tc16 = 1'b0; mpd16 = '0; mpr16 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_prod", 32'(prod), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].p);
      drain();
    end

    // start pulse during RUN with different operands must be ignored.
    issue(12'h123, 8'h04, 1'b0, 20'h0048C);
    @(negedge clk);
    mpd = 12'hFFF; mpr = 8'hFF; tc = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held high through done: second op accepted on the edge after done.
    @(negedge clk);
    mpd = 12'h00A; mpr = 8'h0B; tc = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.p = 32'h0006E; e.due = cyc + ITER;      sb.push_back(e);
      e.p = 32'h00080; e.due = cyc + 2 * ITER + 1; sb.push_back(e);
    end
    @(negedge clk);
    mpd = 12'hFFF; mpr = 8'h80; tc = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset mid-RUN discards the operation (prod is nonzero beforehand).
    issue(12'h0FF, 8'h0F, 1'b0, 20'h00EF1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    check("midrun_reset_prod", 32'(prod), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(12'h003, 8'h05, 1'b0, 20'h0000F);
    drain();

    // 16x16 instance.
    issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    drain();
    issue16(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    drain();
    issue16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    drain();
    issue16(16'h1234, 16'h5678, 1'b0, 32'h06260060);
    drain();
    issue16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    drain();

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
